// File: rtl/signed_div_pkg.sv
// Shared constants and state encoding for the signed sequential divider.
package signed_div_pkg;
  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step on magnitudes: shift in a dividend bit, trial-subtract |b|.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] rem,
  input  logic          din,
  input  logic [VW-1:0] dvs,
  output logic [VW-1:0] rem_nx,
  output logic          qbit
);
  logic [VW:0]   sh;
  logic [VW-1:0] sub;

  assign sh     = {rem, din};
  // When the subtraction succeeds the difference is below dvs, so the low VW bits are exact.
  assign sub    = sh[VW-1:0] - dvs;
  assign qbit   = (sh >= {1'b0, dvs});
  assign rem_nx = qbit ? sub : sh[VW-1:0];
endmodule

// File: rtl/signed_seq_divider.sv
// Signed DW/VW restoring divider, one quotient bit per cycle, result DW+1 edges after start.
// Define SIGNED_DIV_STATUS_EN to add the dz (divide-by-zero) and ovf (MIN/-1) flag ports.
module signed_seq_divider
  import signed_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [DW-1:0] a,
  input  logic signed [VW-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] q,
  output logic signed [VW-1:0] r
`ifdef SIGNED_DIV_STATUS_EN
  ,
  output logic                 dz,
  output logic                 ovf
`endif
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  // areg starts as |a|; dividend bits leave at the top while quotient bits enter at the bottom.
  logic [DW-1:0] areg;
  logic [VW-1:0] rem, bmag, rem_nx;
  logic          sa, sb, bz, qbit;
`ifdef SIGNED_DIV_STATUS_EN
  logic          ov;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == CW'(DW-1)) state_nx = SIGN;
      SIGN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  div_step #(.VW(VW)) u_step (
    .rem    (rem),
    .din    (areg[DW-1]),
    .dvs    (bmag),
    .rem_nx (rem_nx),
    .qbit   (qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      areg <= '0;
      rem  <= '0;
      bmag <= '0;
      sa   <= 1'b0;
      sb   <= 1'b0;
      bz   <= 1'b0;
      done <= 1'b0;
      q    <= '0;
      r    <= '0;
`ifdef SIGNED_DIV_STATUS_EN
      ov   <= 1'b0;
      dz   <= 1'b0;
      ovf  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // -MIN wraps to MIN, whose bit pattern is the correct unsigned magnitude.
          areg <= a[DW-1] ? -a : a;
          bmag <= b[VW-1] ? -b : b;
          sa   <= a[DW-1];
          sb   <= b[VW-1];
          bz   <= (b == '0);
          rem  <= '0;
          cnt  <= '0;
`ifdef SIGNED_DIV_STATUS_EN
          ov   <= (a == {1'b1, {(DW-1){1'b0}}}) && (b == '1);
`endif
        end
        CALC: begin
          rem  <= rem_nx;
          areg <= {areg[DW-2:0], qbit};
          cnt  <= cnt + CW'(1);
        end
        SIGN: begin
          done <= 1'b1;
          // A zero divisor leaves all-ones in areg and junk in rem; force the defined result.
          q    <= bz ? '1 : ((sa ^ sb) ? -areg : areg);
          r    <= bz ? '0 : (sa ? -rem : rem);
`ifdef SIGNED_DIV_STATUS_EN
          dz   <= bz;
          ovf  <= ov;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed and exhaustive checks of signed_seq_divider (DW=8, VW=4), with or without status flags.
module tb_signed_seq_divider;
  localparam int DW = 8;
  localparam int VW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic signed [DW-1:0] a = '0;
  logic signed [VW-1:0] b = '0;
  logic                 busy, done;
  logic signed [DW-1:0] q;
  logic signed [VW-1:0] r;
`ifdef SIGNED_DIV_STATUS_EN
  logic                 dz, ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  signed_seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r)
`ifdef SIGNED_DIV_STATUS_EN
    ,
    .dz    (dz),
    .ovf   (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Truncating signed division reference, plus the two special cases.
  task automatic model(input logic [7:0] x, input logic [3:0] y,
                       output logic [7:0] eq, output logic [3:0] er,
                       output logic ez, output logic eo);
    int xi, yi;
    xi = int'($signed(x));
    yi = int'($signed(y));
    ez = 1'b0;
    eo = 1'b0;
    if (yi == 0) begin
      eq = 8'hFF; er = 4'h0; ez = 1'b1;
    end else if (xi == -128 && yi == -1) begin
      eq = 8'h80; er = 4'h0; eo = 1'b1;
    end else begin
      eq = 8'(xi / yi);
      er = 4'(xi % yi);
    end
  endtask

  // Pulse start with x/y; lat = negedge index (1 = first after the start edge) where done is seen.
  task automatic do_div(input logic [7:0] x, input logic [3:0] y, output int lat, output int bcnt);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (done)      lat = k;
      else if (busy) bcnt++;
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] x, input logic [3:0] y);
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez, eo;
    model(x, y, eq, er, ez, eo);
    chk({tag, ".q"}, {24'b0, q}, {24'b0, eq});
    chk({tag, ".r"}, {28'b0, r}, {28'b0, er});
`ifdef SIGNED_DIV_STATUS_EN
    chk({tag, ".dz"},  {31'b0, dz},  {31'b0, ez});
    chk({tag, ".ovf"}, {31'b0, ovf}, {31'b0, eo});
`else
    if (ez || eo) ; // flags absent in this build
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, bcnt, nd, bad;
    logic [7:0] xs [3];
    logic [3:0] ys [3];
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez, eo;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.q", {24'b0, q}, 32'd0);
    chk("rst.r", {28'b0, r}, 32'd0);
`ifdef SIGNED_DIV_STATUS_EN
    chk("rst.dz", {31'b0, dz}, 32'd0);
    chk("rst.ovf", {31'b0, ovf}, 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // 100 / 7: latency, busy window, result, pulse width, hold
    do_div(8'd100, 4'd7, lat, bcnt);
    chk("p100_7.lat", lat, 32'd10);
    chk("p100_7.busy", bcnt, 32'd9);
    chk("p100_7.q", {24'b0, q}, 32'd14);
    chk("p100_7.r", {28'b0, r}, 32'd2);
    @(negedge clk);
    chk("p100_7.done1", {31'b0, done}, 32'd0);
    chk("p100_7.hold", {24'b0, q}, 32'd14);

    do_div(8'h9C, 4'd7, lat, bcnt);
    chk("m100_7.q", {24'b0, q}, 32'hF2);
    chk("m100_7.r", {28'b0, r}, 32'hE);
    do_div(8'd100, 4'h8, lat, bcnt);
    chk("p100_m8.q", {24'b0, q}, 32'hF4);
    chk("p100_m8.r", {28'b0, r}, 32'h4);

    do_div(8'h80, 4'hF, lat, bcnt);
    chk("ovf.q", {24'b0, q}, 32'h80);
    chk("ovf.r", {28'b0, r}, 32'h0);
`ifdef SIGNED_DIV_STATUS_EN
    chk("ovf.flag", {31'b0, ovf}, 32'd1);
    chk("ovf.dz", {31'b0, dz}, 32'd0);
`endif
    do_div(8'd50, 4'd0, lat, bcnt);
    chk("dz.lat", lat, 32'd10);
    chk("dz.q", {24'b0, q}, 32'hFF);
    chk("dz.r", {28'b0, r}, 32'h0);
`ifdef SIGNED_DIV_STATUS_EN
    chk("dz.flag", {31'b0, dz}, 32'd1);
    chk("dz.ovf", {31'b0, ovf}, 32'd0);
`endif

    // start held high: re-accepted in each done cycle, ignored (with new operands) while busy
    xs = '{8'd37, 8'hB3, 8'd127};
    ys = '{4'hD, 4'd5, 4'h8};
    @(negedge clk);
    a = xs[0]; b = ys[0]; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i < 2) begin a = xs[i+1]; b = ys[i+1]; end
      else start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
        @(negedge clk);
        if (done) lat = k;
      end
      chk($sformatf("b2b%0d.lat", i), lat, 32'd10);
      chk_res($sformatf("b2b%0d", i), xs[i], ys[i]);
      if (i < 2) @(posedge clk);
    end

    // Reset at edge 5 of an operation
    @(negedge clk);
    a = 8'd100; b = 4'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst.busy", {31'b0, busy}, 32'd0);
    chk("mrst.done", {31'b0, done}, 32'd0);
    chk("mrst.q", {24'b0, q}, 32'd0);
    chk("mrst.r", {28'b0, r}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mrst.nodone", nd, 32'd0);
    do_div(8'h9C, 4'd7, lat, bcnt);
    chk("mrst.lat", lat, 32'd10);
    chk_res("mrst", 8'h9C, 4'd7);

    // Exhaustive sweep against the reference model
    bad = 0;
    for (int xi = 0; xi < 256; xi++) begin
      for (int yi = 0; yi < 16; yi++) begin
        do_div(xi[7:0], yi[3:0], lat, bcnt);
        model(xi[7:0], yi[3:0], eq, er, ez, eo);
        if (lat != 10 || q !== eq || r !== er) bad++;
`ifdef SIGNED_DIV_STATUS_EN
        if (dz !== ez || ovf !== eo) bad++;
`endif
      end
    end
    chk("sweep.bad", bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
